// File: rtl/axi_lite_regs_pkg.sv
// axi_lite_regs_pkg
// Shared constants and FSM state types for the AXI4-Lite register slave.
//   RESP_*      : AXI response encodings
//   wr_state_e  : write-channel FSM states
//   rd_state_e  : read-channel FSM states
package axi_lite_regs_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    WR_COLLECT,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_e;

endpackage

// File: rtl/axi_lite_regs_decode.sv
// axi_lite_regs_decode
// Combinational address decoder for the register window.
// Ports:
//   i_addr    in   AddrWidth  byte address from AW or AR
//   o_index   out  IdxW       word index within the window (valid when o_hit)
//   o_hit     out  1          address falls inside the window
//   o_is_ro   out  1          index addresses a read-only status word
module axi_lite_regs_decode
  import axi_lite_regs_pkg::*;
#(
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          DataWidth = 32,
  parameter logic [AddrWidth-1:0] BaseAddr  = 32'hfffc0700,
  parameter int unsigned          NumRegs   = 16,
  parameter int unsigned          NumRw     = 8,
  parameter int unsigned          IdxW      = 4
) (
  input  logic [AddrWidth-1:0] i_addr,
  output logic [IdxW-1:0]      o_index,
  output logic                 o_hit,
  output logic                 o_is_ro
);

  localparam int unsigned Shift = $clog2(DataWidth / 8);

  logic [AddrWidth-1:0] w_off;
  logic [AddrWidth-1:0] w_idx_full;

  // Sub-word address bits are dropped by the shift.
  assign w_off      = i_addr - BaseAddr;
  assign w_idx_full = w_off >> Shift;

  assign o_hit   = (i_addr >= BaseAddr) && (w_idx_full < AddrWidth'(NumRegs));
  assign o_index = w_idx_full[IdxW-1:0];
  assign o_is_ro = (w_idx_full >= AddrWidth'(NumRw));

endmodule

// File: rtl/axi_lite_regs_slave.sv
// axi_lite_regs_slave
// AXI4-Lite subordinate holding NumRw read/write registers and exposing
// NumRegs-NumRw read-only status words. Independent write and read FSMs,
// one outstanding transaction per direction.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   aw_* / w_* / b_*        AXI write address, data, response channels
//   ar_* / r_*              AXI read address and data channels
//   reg_q_o                 packed RW register contents (reg k at k*DataWidth)
//   ro_d_i                  packed RO status words, same packing
//   wr_pulse_o              (only with AXIL_REGS_WR_PULSE_EN) one-cycle pulse per
//                           RW register after an OKAY write commit
module axi_lite_regs_slave
  import axi_lite_regs_pkg::*;
#(
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          DataWidth = 32,
  parameter logic [AddrWidth-1:0] BaseAddr  = 32'hfffc0700,
  parameter int unsigned          NumRegs   = 16,
  parameter int unsigned          NumRw     = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [AddrWidth-1:0]              aw_addr_i,
  input  logic [2:0]                        aw_prot_i,
  input  logic                              aw_valid_i,
  output logic                              aw_ready_o,
  input  logic [DataWidth-1:0]              w_data_i,
  input  logic [DataWidth/8-1:0]            w_strb_i,
  input  logic                              w_valid_i,
  output logic                              w_ready_o,
  output logic [1:0]                        b_resp_o,
  output logic                              b_valid_o,
  input  logic                              b_ready_i,
  input  logic [AddrWidth-1:0]              ar_addr_i,
  input  logic [2:0]                        ar_prot_i,
  input  logic                              ar_valid_i,
  output logic                              ar_ready_o,
  output logic [DataWidth-1:0]              r_data_o,
  output logic [1:0]                        r_resp_o,
  output logic                              r_valid_o,
  input  logic                              r_ready_i,
  output logic [NumRw*DataWidth-1:0]        reg_q_o,
  input  logic [(NumRegs-NumRw)*DataWidth-1:0] ro_d_i
`ifdef AXIL_REGS_WR_PULSE_EN
  ,
  output logic [NumRw-1:0]                  wr_pulse_o
`endif
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdxW      = (NumRegs > 1) ? $clog2(NumRegs) : 1;

  // ---------------------------------------------------------------- write path
  wr_state_e            r_wr_state;
  logic                 r_aw_held, r_w_held;
  logic [AddrWidth-1:0] r_aw_addr;
  logic [DataWidth-1:0] r_w_data;
  logic [StrbWidth-1:0] r_w_strb;
  logic                 r_b_valid;
  logic [1:0]           r_b_resp;
  logic [DataWidth-1:0] r_regs [NumRw];

  logic                 w_aw_hs, w_w_hs, w_commit, w_wr_ok;
  logic [AddrWidth-1:0] w_aw_addr;
  logic [DataWidth-1:0] w_wr_data;
  logic [StrbWidth-1:0] w_wr_strb;
  logic [IdxW-1:0]      w_wr_idx;
  logic                 w_wr_hit, w_wr_is_ro;
  logic [1:0]           w_wr_resp;

  assign aw_ready_o = (r_wr_state == WR_COLLECT) && !r_aw_held;
  assign w_ready_o  = (r_wr_state == WR_COLLECT) && !r_w_held;
  assign w_aw_hs    = aw_valid_i && aw_ready_o;
  assign w_w_hs     = w_valid_i && w_ready_o;

  // Use the latched half if it arrived earlier, otherwise the live channel,
  // so the commit happens in the same cycle the second half is accepted.
  assign w_aw_addr = r_aw_held ? r_aw_addr : aw_addr_i;
  assign w_wr_data = r_w_held ? r_w_data : w_data_i;
  assign w_wr_strb = r_w_held ? r_w_strb : w_strb_i;
  assign w_commit  = (r_wr_state == WR_COLLECT) && (r_aw_held || w_aw_hs) &&
                     (r_w_held || w_w_hs);

  axi_lite_regs_decode #(
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth),
    .BaseAddr  (BaseAddr),
    .NumRegs   (NumRegs),
    .NumRw     (NumRw),
    .IdxW      (IdxW)
  ) u_aw_decode (
    .i_addr  (w_aw_addr),
    .o_index (w_wr_idx),
    .o_hit   (w_wr_hit),
    .o_is_ro (w_wr_is_ro)
  );

  assign w_wr_resp = !w_wr_hit ? RESP_DECERR : (w_wr_is_ro ? RESP_SLVERR : RESP_OKAY);
  assign w_wr_ok   = w_commit && w_wr_hit && !w_wr_is_ro;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_state <= WR_COLLECT;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_aw_addr  <= '0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      r_b_valid  <= 1'b0;
      r_b_resp   <= RESP_OKAY;
      for (int k = 0; k < NumRw; k++) r_regs[k] <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= aw_addr_i;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_w_data <= w_data_i;
        r_w_strb <= w_strb_i;
      end
      unique case (r_wr_state)
        WR_COLLECT: begin
          if (w_commit) begin
            // Later assignments override the latch-set above.
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_b_valid  <= 1'b1;
            r_b_resp   <= w_wr_resp;
            r_wr_state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_ready_i) begin
            r_b_valid  <= 1'b0;
            r_wr_state <= WR_COLLECT;
          end
        end
      endcase
      for (int k = 0; k < NumRw; k++) begin
        if (w_wr_ok && (w_wr_idx == IdxW'(k))) begin
          for (int b = 0; b < StrbWidth; b++) begin
            if (w_wr_strb[b]) r_regs[k][8*b +: 8] <= w_wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  assign b_valid_o = r_b_valid;
  assign b_resp_o  = r_b_resp;

  for (genvar g = 0; g < NumRw; g++) begin : g_reg_out
    assign reg_q_o[g*DataWidth +: DataWidth] = r_regs[g];
  end

`ifdef AXIL_REGS_WR_PULSE_EN
  logic [NumRw-1:0] r_wr_pulse;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_pulse <= '0;
    end else begin
      for (int k = 0; k < NumRw; k++) begin
        r_wr_pulse[k] <= w_wr_ok && (w_wr_idx == IdxW'(k));
      end
    end
  end

  assign wr_pulse_o = r_wr_pulse;
`endif

  // ----------------------------------------------------------------- read path
  rd_state_e            r_rd_state;
  logic                 r_r_valid;
  logic [1:0]           r_r_resp;
  logic [DataWidth-1:0] r_r_data;

  logic                 w_ar_hs;
  logic [IdxW-1:0]      w_rd_idx;
  logic                 w_rd_hit, w_rd_is_ro;
  logic [DataWidth-1:0] w_rd_word;

  assign ar_ready_o = (r_rd_state == RD_IDLE);
  assign w_ar_hs    = ar_valid_i && ar_ready_o;

  axi_lite_regs_decode #(
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth),
    .BaseAddr  (BaseAddr),
    .NumRegs   (NumRegs),
    .NumRw     (NumRw),
    .IdxW      (IdxW)
  ) u_ar_decode (
    .i_addr  (ar_addr_i),
    .o_index (w_rd_idx),
    .o_hit   (w_rd_hit),
    .o_is_ro (w_rd_is_ro)
  );

  // Reads sample r_regs before any same-edge commit lands, so a colliding
  // write is only visible to reads accepted on a later cycle.
  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < NumRw; k++) begin
      if (w_rd_idx == IdxW'(k)) w_rd_word = r_regs[k];
    end
    for (int k = 0; k < NumRegs - NumRw; k++) begin
      if (w_rd_idx == IdxW'(k + NumRw)) w_rd_word = ro_d_i[k*DataWidth +: DataWidth];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_state <= RD_IDLE;
      r_r_valid  <= 1'b0;
      r_r_resp   <= RESP_OKAY;
      r_r_data   <= '0;
    end else begin
      unique case (r_rd_state)
        RD_IDLE: begin
          if (w_ar_hs) begin
            r_r_valid  <= 1'b1;
            r_r_data   <= w_rd_hit ? w_rd_word : '0;
            r_r_resp   <= w_rd_hit ? RESP_OKAY : RESP_DECERR;
            r_rd_state <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (r_ready_i) begin
            r_r_valid  <= 1'b0;
            r_rd_state <= RD_IDLE;
          end
        end
      endcase
    end
  end

  assign r_valid_o = r_r_valid;
  assign r_data_o  = r_r_data;
  assign r_resp_o  = r_r_resp;

endmodule

// File: tb/tb_axi_lite_regs_slave.sv
// tb_axi_lite_regs_slave
// Directed bench for axi_lite_regs_slave. Stimulus tasks push expected B/R
// responses into queues; a negedge monitor pops and compares on each handshake.
module tb_axi_lite_regs_slave;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned NR  = 16;
  localparam int unsigned NRW = 8;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [AW-1:0]     aw_addr_i;
  logic [2:0]        aw_prot_i;
  logic              aw_valid_i;
  logic              aw_ready_o;
  logic [DW-1:0]     w_data_i;
  logic [DW/8-1:0]   w_strb_i;
  logic              w_valid_i;
  logic              w_ready_o;
  logic [1:0]        b_resp_o;
  logic              b_valid_o;
  logic              b_ready_i;
  logic [AW-1:0]     ar_addr_i;
  logic [2:0]        ar_prot_i;
  logic              ar_valid_i;
  logic              ar_ready_o;
  logic [DW-1:0]     r_data_o;
  logic [1:0]        r_resp_o;
  logic              r_valid_o;
  logic              r_ready_i;
  logic [NRW*DW-1:0] reg_q_o;
  logic [(NR-NRW)*DW-1:0] ro_d_i;

  int checks = 0;
  int errors = 0;

  logic [1:0]  b_exp_q[$];
  logic [33:0] r_exp_q[$];
  logic [33:0] mon_r;

  always #5 clk = ~clk;

  axi_lite_regs_slave #(
    .AddrWidth (AW),
    .DataWidth (DW),
    .BaseAddr  (32'hfffc0700),
    .NumRegs   (NR),
    .NumRw     (NRW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .aw_addr_i  (aw_addr_i),
    .aw_prot_i  (aw_prot_i),
    .aw_valid_i (aw_valid_i),
    .aw_ready_o (aw_ready_o),
    .w_data_i   (w_data_i),
    .w_strb_i   (w_strb_i),
    .w_valid_i  (w_valid_i),
    .w_ready_o  (w_ready_o),
    .b_resp_o   (b_resp_o),
    .b_valid_o  (b_valid_o),
    .b_ready_i  (b_ready_i),
    .ar_addr_i  (ar_addr_i),
    .ar_prot_i  (ar_prot_i),
    .ar_valid_i (ar_valid_i),
    .ar_ready_o (ar_ready_o),
    .r_data_o   (r_data_o),
    .r_resp_o   (r_resp_o),
    .r_valid_o  (r_valid_o),
    .r_ready_i  (r_ready_i),
    .reg_q_o    (reg_q_o),
    .ro_d_i     (ro_d_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int k);
    return reg_q_o[k*DW +: DW];
  endfunction

  // Scoreboard monitor: inputs change only #1 after posedge, so a handshake
  // seen here completes on the following posedge.
  always @(negedge clk) begin
    if (!rst_i && b_valid_o && b_ready_i) begin
      if (b_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: got resp %b expected no response", b_resp_o);
      end else begin
        check("b_resp", 32'(b_resp_o), 32'(b_exp_q.pop_front()));
      end
    end
    if (!rst_i && r_valid_o && r_ready_i) begin
      if (r_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL r_unexpected: got %h/%b expected no response", r_data_o, r_resp_o);
      end else begin
        mon_r = r_exp_q.pop_front();
        check("r_data", r_data_o, mon_r[33:2]);
        check("r_resp", 32'(r_resp_o), 32'(mon_r[1:0]));
      end
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp);
    int  n;
    logic aw_go, w_go;
    b_exp_q.push_back(exp);
    aw_addr_i  = addr;
    aw_valid_i = 1'b1;
    w_data_i   = data;
    w_strb_i   = strb;
    w_valid_i  = 1'b1;
    n = 0;
    while ((aw_valid_i || w_valid_i) && n < 20) begin
      aw_go = aw_ready_o;
      w_go  = w_ready_o;
      @(posedge clk);
      #1;
      if (aw_go) aw_valid_i = 1'b0;
      if (w_go)  w_valid_i  = 1'b0;
      n++;
    end
    if (aw_valid_i || w_valid_i) begin
      checks++;
      errors++;
      $display("FAIL write_accept: got no handshake expected AW/W accepted at %h", addr);
      aw_valid_i = 1'b0;
      w_valid_i  = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] exp);
    int  n;
    logic go;
    r_exp_q.push_back({data, exp});
    ar_addr_i  = addr;
    ar_valid_i = 1'b1;
    n = 0;
    while (ar_valid_i && n < 20) begin
      go = ar_ready_o;
      @(posedge clk);
      #1;
      if (go) ar_valid_i = 1'b0;
      n++;
    end
    if (ar_valid_i) begin
      checks++;
      errors++;
      $display("FAIL read_accept: got no handshake expected AR accepted at %h", addr);
      ar_valid_i = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((b_exp_q.size() > 0 || r_exp_q.size() > 0) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (b_exp_q.size() > 0 || r_exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d B/%0d R pending expected 0", b_exp_q.size(), r_exp_q.size());
      b_exp_q.delete();
      r_exp_q.delete();
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i      = 1'b1;
    aw_addr_i  = '0;
    aw_prot_i  = '0;
    aw_valid_i = 1'b0;
    w_data_i   = '0;
    w_strb_i   = '0;
    w_valid_i  = 1'b0;
    b_ready_i  = 1'b1;
    ar_addr_i  = '0;
    ar_prot_i  = '0;
    ar_valid_i = 1'b0;
    r_ready_i  = 1'b1;
    ro_d_i     = '0;
    tick(3);
    rst_i = 1'b0;

    // Reset state
    check("rst_aw_ready", 32'(aw_ready_o), 1);
    check("rst_w_ready", 32'(w_ready_o), 1);
    check("rst_ar_ready", 32'(ar_ready_o), 1);
    check("rst_b_valid", 32'(b_valid_o), 0);
    check("rst_r_valid", 32'(r_valid_o), 0);
    check("rst_b_resp", 32'(b_resp_o), 0);
    check("rst_r_resp", 32'(r_resp_o), 0);
    check("rst_r_data", r_data_o, 0);
    for (int k = 0; k < NRW; k++) check($sformatf("rst_reg%0d", k), word(k), 0);

    // 1: AW and W together, one-cycle B latency
    axi_write(32'hfffc0704, 32'hDEADBEEF, 4'hF, 2'b00);
    check("t1_b_latency", 32'(b_valid_o), 1);
    wait_drain();
    check("t1_reg1", word(1), 32'hDEADBEEF);
    axi_read(32'hfffc0704, 32'hDEADBEEF, 2'b00);
    wait_drain();

    // 2: W three cycles ahead of AW, partial strobe
    w_data_i  = 32'h12345678;
    w_strb_i  = 4'b0011;
    w_valid_i = 1'b1;
    tick(1);
    w_valid_i = 1'b0;
    check("t2_w_ready_drop", 32'(w_ready_o), 0);
    check("t2_aw_ready_kept", 32'(aw_ready_o), 1);
    tick(2);
    check("t2_no_b_early", 32'(b_valid_o), 0);
    check("t2_w_ready_low", 32'(w_ready_o), 0);
    b_exp_q.push_back(2'b00);
    aw_addr_i  = 32'hfffc0700;
    aw_valid_i = 1'b1;
    tick(1);
    aw_valid_i = 1'b0;
    check("t2_b_latency", 32'(b_valid_o), 1);
    wait_drain();
    check("t2_reg0", word(0), 32'h00005678);
    tick(3);
    check("t2_single_b", 32'(b_valid_o), 0);

    // 3: RO words: write rejected, read returns sampled status
    ro_d_i[0*DW +: DW] = 32'hCAFE0001;
    ro_d_i[1*DW +: DW] = 32'h0BAD0002;
    ro_d_i[7*DW +: DW] = 32'h77770007;
    axi_write(32'hfffc0720, 32'h11111111, 4'hF, 2'b10);
    wait_drain();
    check("t3_reg0_kept", word(0), 32'h00005678);
    check("t3_reg1_kept", word(1), 32'hDEADBEEF);
    axi_read(32'hfffc0720, 32'hCAFE0001, 2'b00);
    wait_drain();
    axi_read(32'hfffc0724, 32'h0BAD0002, 2'b00);
    wait_drain();
    axi_read(32'hfffc073c, 32'h77770007, 2'b00);
    wait_drain();

    // 4: out-of-range and below-base decode, boundary indices
    axi_read(32'hfffc0800, 32'h0, 2'b11);
    wait_drain();
    axi_read(32'hfffc0740, 32'h0, 2'b11);
    wait_drain();
    axi_read(32'hfffc06fc, 32'h0, 2'b11);
    wait_drain();
    axi_write(32'hfffc0800, 32'hFFFFFFFF, 4'hF, 2'b11);
    wait_drain();
    axi_write(32'hfffc06fc, 32'hFFFFFFFF, 4'hF, 2'b11);
    wait_drain();
    check("t4_reg0_kept", word(0), 32'h00005678);
    check("t4_reg7_kept", word(7), 32'h0);
    axi_write(32'hfffc071c, 32'hA5A5A5A5, 4'hF, 2'b00);
    wait_drain();
    check("t4_reg7_last_rw", word(7), 32'hA5A5A5A5);
    axi_write(32'hfffc0708, 32'hFFFFFFFF, 4'h0, 2'b00);
    wait_drain();
    check("t4_strb0_no_change", word(2), 32'h0);
    axi_write(32'hfffc070b, 32'hAB000000, 4'b1000, 2'b00);
    wait_drain();
    check("t4_subword_ignored", word(2), 32'hAB000000);

    // Read/write collision on reg 3: same cycle sees old, next cycle sees new
    fork
      axi_write(32'hfffc070c, 32'h13572468, 4'hF, 2'b00);
      axi_read(32'hfffc070c, 32'h00000000, 2'b00);
    join
    wait_drain();
    fork
      axi_write(32'hfffc070c, 32'h24681357, 4'hF, 2'b00);
      begin
        tick(1);
        axi_read(32'hfffc070c, 32'h24681357, 2'b00);
      end
    join
    wait_drain();

    // 5: backpressure on B and R
    b_ready_i = 1'b0;
    axi_write(32'hfffc0710, 32'h44444444, 4'hF, 2'b00);
    for (int i = 0; i < 5; i++) begin
      check("t5_b_valid_hold", 32'(b_valid_o), 1);
      check("t5_b_resp_hold", 32'(b_resp_o), 0);
      check("t5_aw_blocked", 32'(aw_ready_o), 0);
      check("t5_w_blocked", 32'(w_ready_o), 0);
      tick(1);
    end
    b_ready_i = 1'b1;
    wait_drain();
    check("t5_aw_ready_back", 32'(aw_ready_o), 1);
    r_ready_i = 1'b0;
    axi_read(32'hfffc0710, 32'h44444444, 2'b00);
    for (int i = 0; i < 5; i++) begin
      check("t5_r_valid_hold", 32'(r_valid_o), 1);
      check("t5_r_data_hold", r_data_o, 32'h44444444);
      check("t5_ar_blocked", 32'(ar_ready_o), 0);
      tick(1);
    end
    r_ready_i = 1'b1;
    wait_drain();
    check("t5_ar_ready_back", 32'(ar_ready_o), 1);

    // 6: reset while B is pending drops the response
    b_ready_i = 1'b0;
    axi_write(32'hfffc0714, 32'h55555555, 4'hF, 2'b00);
    check("t6_b_pending", 32'(b_valid_o), 1);
    check("t6_reg5_written", word(5), 32'h55555555);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    b_exp_q.delete();
    check("t6_b_valid_cleared", 32'(b_valid_o), 0);
    check("t6_aw_ready", 32'(aw_ready_o), 1);
    check("t6_w_ready", 32'(w_ready_o), 1);
    check("t6_ar_ready", 32'(ar_ready_o), 1);
    for (int k = 0; k < NRW; k++) check($sformatf("t6_reg%0d", k), word(k), 0);
    b_ready_i = 1'b1;
    tick(2);

    // Normal operation after reset
    axi_write(32'hfffc0718, 32'h00CC0000, 4'b0100, 2'b00);
    wait_drain();
    check("post_rst_reg6", word(6), 32'h00CC0000);
    axi_read(32'hfffc0718, 32'h00CC0000, 2'b00);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
